// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encodings and constants for the UART receiver
package uart_rx_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;
    localparam int UART_DATA_BITS = 8;
    localparam logic [15:0] BAUD_DIV_MIN = 16'd3;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver configuration, serial pin and byte-strobe outputs
interface uart_rx_if;
    logic [15:0] baudrate_div;
    logic uart_rxd;
    logic [uart_rx_pkg::UART_DATA_BITS-1:0] rx_data;
    logic rx_valid;
    logic rx_framing_err;
    logic rx_busy;
    modport master (
        output baudrate_div, uart_rxd,
        input  rx_data, rx_valid, rx_framing_err, rx_busy
    );
    modport slave (
        input  baudrate_div, uart_rxd,
        output rx_data, rx_valid, rx_framing_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the RXD pin plus falling-edge detect
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rxd_s,
    output logic fall
);
    logic s1, rxd_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            s1    <= RST_VAL;
            rxd_s <= RST_VAL;
            rxd_q <= RST_VAL;
        end else begin
            s1    <= d;
            rxd_s <= s1;
            rxd_q <= rxd_s;
        end
    assign fall = rxd_q & ~rxd_s;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, mid-bit sampling, one-cycle byte/framing-error strobes
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input logic clk,
    input logic rst,
    uart_rx_if.slave bus
);
    localparam int IW = $clog2(DATA_BITS);
    state_t state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [DATA_BITS-1:0] shift_r, shift_n, data_q, data_n;
    logic valid_q, valid_n, ferr_q, ferr_n;
    logic rxd_s, fall;
    logic [15:0] half;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.uart_rxd),
        .rxd_s(rxd_s),
        .fall (fall)
    );

    assign half = bus.baudrate_div >> 1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= BREAK;
            cnt     <= '0;
            idx     <= '0;
            shift_r <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shift_r <= shift_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        idx_n   = idx;
        shift_n = shift_r;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE:
                if (fall) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            START:
                if (cnt == half) begin
                    state_n = rxd_s ? IDLE : DATA;
                    cnt_n   = '0;
                    idx_n   = '0;
                end
            DATA:
                if (cnt == bus.baudrate_div) begin
                    shift_n = {rxd_s, shift_r[DATA_BITS-1:1]};
                    idx_n   = idx + 1'b1;
                    cnt_n   = '0;
                    state_n = (idx == IW'(DATA_BITS - 1)) ? STOP : DATA;
                end
            STOP:
                if (cnt == bus.baudrate_div) begin
                    state_n = rxd_s ? IDLE : BREAK;
                    data_n  = rxd_s ? shift_r : data_q;
                    valid_n = rxd_s;
                    ferr_n  = ~rxd_s;
                    cnt_n   = '0;
                end
            BREAK:
                // wait for the synchronizer to flush its reset-value ones before trusting rxd_s
                if (rxd_s && cnt >= 16'd2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            default: begin
                state_n = BREAK;
                cnt_n   = '0;
            end
        endcase
    end

    assign bus.rx_data        = data_q;
    assign bus.rx_valid       = valid_q;
    assign bus.rx_framing_err = ferr_q;
    assign bus.rx_busy        = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, frames driven bit-by-bit on the pin
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_rx_if bus();

    uart_rx dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int t_edge = 0;
    bit chk_lat = 1'b0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every byte strobe must match the oldest expected byte
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_valid++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got=%h required=none", bus.rx_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.rx_data !== mon_exp) begin
                    bad++;
                    $display("FAIL rx_data got=%h required=%h", bus.rx_data, mon_exp);
                end
            end
            if (chk_lat) begin
                chk_lat = 1'b0;
                total++;
                if (cyc - t_edge < 117 || cyc - t_edge > 118) begin
                    bad++;
                    $display("FAIL latency got=%0d required=117..118", cyc - t_edge);
                end
            end
        end
        if (bus.rx_framing_err) n_ferr++;
        if (bus.rx_valid || bus.rx_framing_err) begin
            total++;
            if (prev_v || prev_e || (bus.rx_valid && bus.rx_framing_err)) begin
                bad++;
                $display("FAIL strobe_shape got=v%b e%b prev=v%b e%b required=single-cycle exclusive",
                         bus.rx_valid, bus.rx_framing_err, prev_v, prev_e);
            end
        end
        prev_v = bus.rx_valid;
        prev_e = bus.rx_framing_err;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int p, input logic stop);
        bus.uart_rxd = 1'b0;
        t_edge = cyc;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rxd = b[i];
            repeat (p) @(negedge clk);
        end
        bus.uart_rxd = stop;
        repeat (p) @(negedge clk);
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        wait_clk(3);
        total += 4;
        if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h required=00", bus.rx_data); end
        if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b required=0", bus.rx_valid); end
        if (bus.rx_framing_err !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b required=0", bus.rx_framing_err); end
        if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b required=1", bus.rx_busy); end
        rst = 1'b0;
        wait_clk(2);
        total++;
        if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL busy_2clk got=%b required=1", bus.rx_busy); end
        wait_clk(1);
        total++;
        if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL busy_3clk got=%b required=0", bus.rx_busy); end
    endtask

    task automatic test_good_frame;
        int vb, fb;
        vb = n_valid;
        fb = n_ferr;
        wait_clk(5);
        exp_q.push_back(8'hA5);
        chk_lat = 1'b1;
        send_frame(8'hA5, 12, 1'b1);
        wait_clk(12);
        drain(50);
        total += 3;
        if (n_valid !== vb + 1) begin bad++; $display("FAIL good_count got=%0d required=%0d", n_valid - vb, 1); end
        if (n_ferr !== fb) begin bad++; $display("FAIL good_ferr got=%0d required=0", n_ferr - fb); end
        if (chk_lat) begin bad++; chk_lat = 1'b0; $display("FAIL good_latency got=unmeasured required=measured"); end
    endtask

    task automatic test_back_to_back;
        int vb;
        logic [7:0] v [3];
        vb = n_valid;
        v = '{8'h00, 8'hFF, 8'h55};
        for (int i = 0; i < 3; i++) exp_q.push_back(v[i]);
        for (int i = 0; i < 3; i++) send_frame(v[i], 12, 1'b1);
        wait_clk(12);
        drain(50);
        total++;
        if (n_valid !== vb + 3) begin bad++; $display("FAIL b2b_count got=%0d required=3", n_valid - vb); end
    endtask

    task automatic test_glitch;
        int vb, fb, n;
        bit seen;
        vb = n_valid;
        fb = n_ferr;
        seen = 1'b0;
        n = 0;
        bus.uart_rxd = 1'b0;
        wait_clk(4);
        bus.uart_rxd = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.rx_busy) seen = 1'b1; else @(negedge clk);
        end
        total++;
        if (!seen) begin bad++; $display("FAIL glitch_start got=busy0 required=busy1"); end
        while (bus.rx_busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n > 10) begin bad++; $display("FAIL glitch_busy got=%0d clocks required<=10", n); end
        wait_clk(30);
        total++;
        if (n_valid !== vb || n_ferr !== fb) begin
            bad++;
            $display("FAIL glitch_strobe got=v%0d e%0d required=v0 e0", n_valid - vb, n_ferr - fb);
        end
    endtask

    task automatic test_framing_error;
        int vb, fb;
        vb = n_valid;
        fb = n_ferr;
        send_frame(8'h3C, 12, 1'b0);
        wait_clk(36);
        total += 4;
        if (n_ferr !== fb + 1) begin bad++; $display("FAIL ferr_count got=%0d required=1", n_ferr - fb); end
        if (n_valid !== vb) begin bad++; $display("FAIL ferr_valid got=%0d required=0", n_valid - vb); end
        if (bus.rx_data !== 8'h55) begin bad++; $display("FAIL ferr_data got=%h required=55", bus.rx_data); end
        if (bus.rx_busy !== 1'b1) begin bad++; $display("FAIL ferr_break got=%b required=1", bus.rx_busy); end
        bus.uart_rxd = 1'b1;
        wait_clk(8);
        total++;
        if (bus.rx_busy !== 1'b0) begin bad++; $display("FAIL ferr_idle got=%b required=0", bus.rx_busy); end
        exp_q.push_back(8'h81);
        send_frame(8'h81, 12, 1'b1);
        wait_clk(12);
        drain(50);
        total++;
        if (n_valid !== vb + 1) begin bad++; $display("FAIL ferr_next got=%0d required=1", n_valid - vb); end
    endtask

    task automatic test_reset_mid_frame;
        int vb, fb, n;
        bit busy_drop;
        logic [7:0] b;
        vb = n_valid;
        fb = n_ferr;
        busy_drop = 1'b0;
        b = 8'h6B;
        bus.uart_rxd = 1'b0;
        wait_clk(12);
        for (int i = 0; i < 4; i++) begin
            bus.uart_rxd = b[i];
            wait_clk(12);
        end
        bus.uart_rxd = b[4];
        wait_clk(6);
        rst = 1'b1;
        bus.uart_rxd = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.rx_busy !== 1'b1) busy_drop = 1'b1;
        end
        total += 3;
        if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_data got=%h required=00", bus.rx_data); end
        if (busy_drop) begin bad++; $display("FAIL rstmid_busy got=dropped required=held1"); end
        if (n_valid !== vb || n_ferr !== fb) begin
            bad++;
            $display("FAIL rstmid_strobe got=v%0d e%0d required=v0 e0", n_valid - vb, n_ferr - fb);
        end
        bus.uart_rxd = 1'b1;
        n = 0;
        while (bus.rx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n > 6) begin bad++; $display("FAIL rstmid_idle got=%0d clocks required<=6", n); end
        wait_clk(150);
        total++;
        if (n_valid !== vb || n_ferr !== fb) begin
            bad++;
            $display("FAIL rstmid_late got=v%0d e%0d required=v0 e0", n_valid - vb, n_ferr - fb);
        end
    endtask

    task automatic test_rate_margin;
        int vb, fb;
        int per [2];
        logic [7:0] v [3];
        vb = n_valid;
        fb = n_ferr;
        per = '{100, 108};
        v = '{8'hC3, 8'h5A, 8'h01};
        bus.baudrate_div = 16'd103;
        wait_clk(10);
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 3; i++) begin
                exp_q.push_back(v[i] ^ 8'(j));
                send_frame(v[i] ^ 8'(j), per[j], 1'b1);
            end
        wait_clk(100);
        drain(300);
        total += 2;
        if (n_valid !== vb + 6) begin bad++; $display("FAIL rate_count got=%0d required=6", n_valid - vb); end
        if (n_ferr !== fb) begin bad++; $display("FAIL rate_ferr got=%0d required=0", n_ferr - fb); end
    endtask

    initial begin
        bus.uart_rxd = 1'b1;
        bus.baudrate_div = 16'd11;
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_rate_margin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side companion of the UART transmitter, on the 12 MHz system clock. It synchronizes the external RXD pin and detects the start bit. It samples 8N1 frames (start, 8 data bits LSB first, one stop bit) at mid-bit using the same `baudrate_div` register value as the transmitter, and presents each byte as a one-cycle strobe to the register/FIFO layer.

## Interface
- `DATA_BITS`, default 8: data bits per frame; fixed at 8 for this design and carried only as a named constant.
- `clk`  in  1  system clock, 12 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `baudrate_div`  in  16  bit period minus one; one bit lasts P = `baudrate_div`+1 clocks. Legal range is ≥ 3. It must be quasi-static while a frame is in progress.
- `uart_rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_data`  out  8  last received byte; holds its value until the next good frame.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` is new.
- `rx_framing_err`  out  1  one-cycle strobe: the stop bit sampled 0.
- `rx_busy`  out  1  high while in any state other than IDLE.

## Operation
- **Input path**
  - `uart_rxd` passes through 2 flops to produce `rxd_s`. Both flops reset to 1.
  - `rxd_q` is `rxd_s` delayed by 1 clock; it also resets to 1.
  - All FSM decisions use `rxd_s` only.
- **Counter:** 16-bit `cnt`, cleared on every state entry, increments by 1 per clock.
- **States: IDLE, START, DATA, STOP, BREAK.**
  - **IDLE:** when `rxd_q`=1 and `rxd_s`=0 (falling edge), go to START.
  - **START:** when `cnt` == `baudrate_div`>>1 (truncating shift), sample `rxd_s`.
    - Sample is 0: go to DATA with bit index 0.
    - Sample is 1: false start; go to IDLE with no strobe.
  - **DATA:** when `cnt` == `baudrate_div`, shift `rxd_s` into `shift_r` MSB-first, so that after 8 samples bit 0 sits in LSB.
    - Increment the bit index and clear `cnt`.
    - After the 8th sample, go to STOP.
  - **STOP:** when `cnt` == `baudrate_div`, sample `rxd_s`.
    - Sample is 1: load `rx_data` <= `shift_r`, pulse `rx_valid`, go to IDLE.
    - Sample is 0: pulse `rx_framing_err`, leave `rx_data` unchanged, go to BREAK.
  - **BREAK:** remain until `rxd_s`=1, then go to IDLE.
- **Reset:**
  - The FSM enters BREAK, so a line held low through reset never produces a false frame.
  - Output reset values: `rx_data`=0x00, `rx_valid`=0, `rx_framing_err`=0, `rx_busy`=1 (BREAK). `rx_busy` drops to 0 after 3 clocks if the line is high.
- **Reset mid-frame:** the partial frame is discarded and no strobe is issued.
- **No flow control:** the consumer must take `rx_data` within one frame time. A new byte overwrites the old one unconditionally.
- `rx_valid` and `rx_framing_err` are never high in the same cycle.

## Timing
- **Start detection:** a falling edge on the pin is seen as `rxd_s` low 2–3 clocks later. The edge is detected in the first cycle where `rxd_s`=0, which is cycle E. START is entered at E+1.
- **Sample points** (relative to E+1, where `cnt`=0):
  - start-bit sample at +(`baudrate_div`>>1);
  - data bit k sample at +(`baudrate_div`>>1) + (k+1)·P;
  - stop sample at +(`baudrate_div`>>1) + 9·P.
- **Output timing:** `rx_valid` / `rx_framing_err` are registered and are high exactly in the single cycle after the stop-sample cycle.
- **Back-to-back frames:** the FSM returns to IDLE ≈P/2 before the end of the stop bit. A start edge arriving immediately after the stop bit is therefore caught with no gap required.
- **Tolerance:** the transmitter/receiver period mismatch must stay within ±4.5 % over a frame.

## Structure
- Shared package/header `uart_defs` holds:
  - FSM state encodings (3-bit: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4);
  - `UART_DATA_BITS`=8;
  - the minimum legal `baudrate_div`.
- One natural sub-module, `uart_rx_sync`: the 2-flop synchronizer plus edge register. It has a parameterized reset value of 1 and outputs `rxd_s` and `fall`.
- Everything else stays in `uart_rx`.

## Test plan
- **Good frame:** `baudrate_div`=11 (P=12). Drive byte 0xA5 as an 8N1 frame.
  - `rx_valid` pulses once for 1 cycle with `rx_data`=0xA5.
  - The pulse occurs 2–3 + 1 + 5 + 108 + 1 clocks after the start edge on the pin.
  - `rx_framing_err` stays 0.
- **Back-to-back:** 0x00, 0xFF, 0x55 with zero idle between frames. Three `rx_valid` pulses in order with the correct data.
- **Glitch:** a low pulse of 4 clocks on `uart_rxd`. A false start is detected; there is no strobe, and `rx_busy` returns to 0 within P/2+4 clocks.
- **Framing error:** frame 0x3C with stop bit driven 0, then the line held low for 3P. `rx_framing_err` pulses once, `rx_data` keeps its previous value, and the FSM stays in BREAK until the line goes high. The next good frame 0x81 is received correctly.
- **Reset:** assert `rst` during data bit 4, then release it with the line low for 2P. All outputs are at their reset values, there are no strobes, and `rx_busy`=1 until the line returns high.
- **Rate margin:** `baudrate_div`=103 (115.2 kbaud). Frames are sent at P=99 and at P=109 (±4.8 % is outside the tolerance; use P=100 and P=108). All bytes are received correctly.
